cla_pipe_addsub: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the RV32 datapath.
//  - Splits a WIDTH-bit add/sub into BLOCK-bit CLA groups with group-level lookahead.
//  - Registers the inter-group carry between STAGES pipeline stages.
//  - Valid/ready handshakes on input and output, plus carry/overflow/zero flags.
//  - Used by the ALU/address path wherever a single-cycle 32-bit ripple of groups misses timing.

---
 rtl/cla_pipe_addsub.sv | 190 +++++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH bits split into STAGES slices of
// BLOCK-bit lookahead groups, with the inter-slice carry registered and valid/ready flow control.
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SLICE  = WIDTH / STAGES;
  localparam int GROUPS = SLICE / BLOCK;

  if ((STAGES < 1) || (WIDTH % (STAGES * BLOCK) != 0)) begin : g_param_check
    $fatal(1, "cla_pipe_addsub: WIDTH must be a multiple of STAGES*BLOCK");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] v_in;

  // A stage may move when it is empty or the stage after it is moving.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = ~v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~v_q[k] | adv[k+1];
    end
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[STAGES-1];

  always_comb begin
    v_in    = '0;
    v_in[0] = in_valid & in_ready;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
    end
  end

  // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (flush) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) v_q[k] <= v_in[k];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;     // sum bits already finished before this stage
    localparam int REM = WIDTH - LO;    // operand bits still to be summed

    logic [REM-1:0]      op_a;
    logic [REM-1:0]      op_b;
    logic                op_sub;
    logic                op_c;
    logic [SLICE-1:0]    b_eff;
    logic [SLICE-1:0]    g;
    logic [SLICE-1:0]    p;
    logic [GROUPS-1:0]   gg;
    logic [GROUPS-1:0]   gp;
    logic [GROUPS:0]     gc;
    logic [SLICE:0]      c;
    logic                term;
    logic [SLICE-1:0]    sl_sum;
    logic [LO+SLICE-1:0] s_done;

    if (k == 0) begin : g_src
      assign op_a   = a;
      assign op_b   = b;
      assign op_sub = sub;
      assign op_c   = sub | cin;
      assign s_done = sl_sum;
    end else begin : g_src
      assign op_a   = g_stage[k-1].g_fwd.a_q;
      assign op_b   = g_stage[k-1].g_fwd.b_q;
      assign op_sub = g_stage[k-1].g_fwd.sub_q;
      assign op_c   = g_stage[k-1].g_fwd.c_q;
      assign s_done = {sl_sum, g_stage[k-1].g_fwd.s_q};
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
      b_eff = op_b[SLICE-1:0] ^ {SLICE{op_sub}};
      g     = op_a[SLICE-1:0] & b_eff;
      p     = op_a[SLICE-1:0] ^ b_eff;
      gg    = '0;
      gp    = '0;
      gc    = '0;
      c     = '0;
      term  = 1'b0;
      for (int j = 0; j < GROUPS; j++) begin
        gp[j] = &p[j*BLOCK +: BLOCK];
        for (int t = 0; t < BLOCK; t++) begin
          term = g[j*BLOCK + t];
          for (int m = t + 1; m < BLOCK; m++) term = term & p[j*BLOCK + m];
          gg[j] = gg[j] | term;
        end
      end
      // Group carries in flat sum-of-products form: no ripple from group to group.
      for (int j = 0; j <= GROUPS; j++) begin
        term = op_c;
        for (int i = 0; i < j; i++) term = term & gp[i];
        gc[j] = term;
        for (int i = 0; i < j; i++) begin
          term = gg[i];
          for (int m = i + 1; m < j; m++) term = term & gp[m];
          gc[j] = gc[j] | term;
        end
      end
      for (int j = 0; j < GROUPS; j++) begin
        for (int t = 0; t < BLOCK; t++) begin
          term = gc[j];
          for (int m = 0; m < t; m++) term = term & p[j*BLOCK + m];
          c[j*BLOCK + t] = term;
          for (int i = 0; i < t; i++) begin
            term = g[j*BLOCK + i];
            for (int m = i + 1; m < t; m++) term = term & p[j*BLOCK + m];
            c[j*BLOCK + t] = c[j*BLOCK + t] | term;
          end
        end
      end
      c[SLICE] = gc[GROUPS];
    end

    assign sl_sum = p ^ c[SLICE-1:0];

    if (k < STAGES - 1) begin : g_fwd
      localparam int HI = REM - SLICE;
      logic [HI-1:0]       a_q;
      logic [HI-1:0]       b_q;
      logic                sub_q;
      logic                c_q;
      logic [LO+SLICE-1:0] s_q;

      // NOTE: data registers are reset as well; they are plain flops, not a memory array.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sub_q <= 1'b0;
          c_q   <= 1'b0;
          s_q   <= '0;
        end else if (adv[k] && v_in[k]) begin
          a_q   <= op_a[REM-1:SLICE];
          b_q   <= op_b[REM-1:SLICE];
          sub_q <= op_sub;
          c_q   <= c[SLICE];
          s_q   <= s_done;
        end
      end
    end else begin : g_out
      // Result registers only load on a real result, so they hold while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum  <= '0;
          cout <= 1'b0;
          ovf  <= 1'b0;
          zero <= 1'b0;
        end else if (adv[k] && v_in[k]) begin
          sum  <= s_done;
          cout <= c[SLICE];
          ovf  <= c[SLICE] ^ c[SLICE-1];
          zero <= ~|s_done;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (32/4/2): directed corner cases, backpressure,
// reset/flush, and randomized traffic scored against an arithmetic reference model.
module tb_cla_pipe_addsub;

  localparam int WIDTH  = 32;
  localparam int BLOCK  = 4;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  res_t sb_q[$];
  logic held = 1'b0;
  res_t held_val;
  logic obs_valid;
  res_t obs_res;

  cla_pipe_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the true unsigned and signed values.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    res_t        r;
    longint      ux, uy, sx, sy, u, s;
    logic [31:0] low;
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (sb) begin
      u      = ux - uy;
      s      = sx - sy;
      r.cout = (ux >= uy);
    end else begin
      u      = ux + uy + longint'(ci);
      s      = sx + sy + longint'(ci);
      r.cout = (u >= 64'h1_0000_0000);
    end
    low   = u[31:0];
    r.sum = low;
    r.ovf = (s != longint'($signed(low)));
    r.zero = (low == 32'd0);
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, observe/score, then pass the rising edge.
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ic, input logic is, input logic ordy, input logic fl,
                      output logic rdy);
    res_t cur, exp;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = ic;
    sub       = is;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy       = in_ready;
    cur       = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
    obs_valid = out_valid;
    obs_res   = cur;
    if (fl) check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    if (held) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", {29'd0, cur}, {29'd0, held_val});
    end
    if (out_valid && out_ready) begin
      n_out++;
      if (sb_q.size() == 0) begin
        check("spurious_output", {29'd0, cur}, 64'd0 - 64'd1);
      end else begin
        exp = sb_q.pop_front();
        check("result", {29'd0, cur}, {29'd0, exp});
      end
    end
    held     = out_valid && !out_ready && !fl;
    held_val = cur;
    if (iv && rdy) sb_q.push_back(model(ia, ib, ic, is));
    if (fl) sb_q.delete();
    @(posedge clk);
  endtask

  task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ic, input logic is, input logic [31:0] e_sum,
                          input logic e_cout, input logic e_ovf, input logic e_zero);
    logic rdy;
    int   lat;
    step(1'b1, ia, ib, ic, is, 1'b1, 1'b0, rdy);
    check({tag, "_accept"}, {63'd0, rdy}, 64'd1);
    lat = 0;
    do begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
      lat++;
    end while (!obs_valid && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(STAGES));
    check({tag, "_sum"}, {32'd0, obs_res.sum}, {32'd0, e_sum});
    check({tag, "_flags"}, {61'd0, obs_res.cout, obs_res.ovf, obs_res.zero},
          {61'd0, e_cout, e_ovf, e_zero});
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic        rdy;
    int          sent;
    int          out_before;
    logic [31:0] bp_a[6];
    logic [31:0] bp_b[6];

    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", {32'd0, sum}, 64'd0);
    check("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("cin_ovf",   32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    directed("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    directed("sub_zero_b", 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    directed("sub_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: six ops offered while the consumer stalls for four cycles.
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = $urandom();
      bp_b[i] = $urandom();
    end
    sent = 0;
    out_before = n_out;
    for (int cyc = 0; cyc < 40 && !(sent == 6 && sb_q.size() == 0); cyc++) begin
      step(sent < 6, bp_a[sent % 6], bp_b[sent % 6], 1'(cyc & 1), 1'(sent & 1),
           cyc >= 4, 1'b0, rdy);
      if (cyc == 2 || cyc == 3) check("bp_in_ready_full", {63'd0, rdy}, 64'd0);
      if (sent < 6 && rdy) sent++;
    end
    check("bp_sent", 64'(sent), 64'd6);
    check("bp_outputs", 64'(n_out - out_before), 64'd6);
    check("bp_drained", 64'(sb_q.size()), 64'd0);

    // Asynchronous reset with results in flight.
    step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    step(1'b1, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0, 1'b0, 1'b0, rdy);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    check("rst_pre_valid", {63'd0, obs_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_sum", {32'd0, sum}, 64'd0);
    sb_q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    check("post_rst_idle", {63'd0, obs_valid}, 64'd0);

    // Flush with two ops in flight; the op offered during flush is discarded.
    step(1'b1, 32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    step(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, rdy);
    step(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, rdy);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    check("flush_out_valid", {63'd0, obs_valid}, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    check("post_flush_idle", {63'd0, obs_valid}, 64'd0);

    // Randomized traffic with random stalls, scored in order against the model.
    for (int i = 0; i < 14000; i++) begin
      step($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, 1'b0, rdy);
    end
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, rdy);
    end
    check("final_drain", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
